noc_packet_checker: RTL and testbench
=====================================

# noc_packet_checker

Endpoint receive-side block that consumes flits delivered by a router's local output port over the `receive_*` valid/ready interface. It tracks packet framing, checks each header's destination against its own `X_ID`/`Y_ID`, checks payload content, and keeps saturating statistics. It is the sink-and-check counterpart of a traffic-generating node and is used in NoC test meshes to close the loop on injected traffic.

## Interface
- `X_ID`, 0, this node's X coordinate, `Noc_ID_X_Width` bits
- `Y_ID`, 0, this node's Y coordinate, `Noc_ID_Y_Width` bits
- `noc_clk`  in  1  clock; single clock domain
- `noc_rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  when 0, `receive_ready` = 0 and no flits are accepted
- `clear_stats`  in  1  synchronous clear of all counters and `err_flag`
- `receive_valid`  in  1  flit present
- `receive_ready`  out  1  checker accepts the flit this cycle
- `receive_flit`  in  `Noc_Data_Width`  flit data
- `receive_is_header`  in  1  first flit of a packet
- `receive_is_tail`  in  1  last flit of a packet
- `pkt_count`  out  32  good packets received, saturating
- `flit_count`  out  32  flits accepted, saturating
- `err_count`  out  16  errors detected, saturating
- `err_flag`  out  1  sticky; set on the first error
- `pkt_done`  out  1  one-cycle pulse when any tail is accepted
- `pkt_good`  out  1  valid with `pkt_done`; 1 = packet had no error
- `last_src_x`, `last_src_y`  out  X/Y widths  source ID of the last accepted header

## Operation
- Transfer happens when `receive_valid` and `receive_ready` are both 1 on a rising edge. Flit fields are sampled only on transfer.
- Header layout, from the LSB up: `dst_x` [Xw-1:0], `dst_y` [Xw+Yw-1:Xw], `src_x`, `src_y`. Higher bits are ignored.
- Payload rule: the i-th non-header flit of a packet (i = 1, 2, …) must equal i in bits [15:0]. Bits above 15 are ignored.
- FSM states:
  - IDLE (expect header).
  - BODY (expect payload or tail).
- Transitions out of IDLE:
  - Header without tail goes to BODY. It loads `last_src`, clears the packet-bad bit, sets the index to 1, and checks the destination.
  - Header with tail is a single-flit packet. It completes immediately and stays in IDLE.
  - A non-header flit is an orphan. It is an error, is counted in `flit_count`, stays in IDLE, and produces no `pkt_done`.
- Transitions in BODY:
  - A payload flit checks data, then increments the index. The index saturates at 0xFFFF.
  - A tail checks data, then completes the packet and returns to IDLE.
  - A header is an error and aborts the current packet with no `pkt_done`. The header is then processed as a fresh header, following the IDLE rules.
- Destination mismatch counts as one error and marks the packet bad. The packet is still consumed to its tail.
- Each payload mismatch counts as one error.
- Completion pulses `pkt_done`. `pkt_good` is 1 when the packet-bad bit is clear. `pkt_count` increments only when the packet is good.
- Error accounting: at most one `err_count` increment per cycle. If a flit has both a framing error and a data error, it counts as 1.
- All counters saturate at all-ones and never wrap.
- `clear_stats` takes priority over a same-cycle increment: counters become 0. It does not alter FSM state.

## Timing
- Reset values: FSM = IDLE, all counters 0, `err_flag` 0, `pkt_done` 0, `pkt_good` 0, `last_src_*` 0, `receive_ready` 0 during reset.
- `receive_ready` is a registered copy of `enable`, gated by the backpressure option. It has no combinational path from `receive_valid`.
- Statistics, `err_flag` and `last_src_*` update on the edge after the transfer (1-cycle latency).
- `pkt_done` is asserted in the cycle after the tail transfer.
- Throughput is one flit per cycle when ready is held.
- Reset asserted mid-packet returns the FSM to IDLE. The next flit must be a header, otherwise it is an orphan.
- `enable` dropped mid-packet keeps the FSM state; the packet resumes when `enable` returns.

## Configuration
- `NOC_CHECKER_BACKPRESSURE_EN`
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle. `receive_ready` is deasserted whenever LFSR[1:0] == 2'b00, roughly 25% stall.
  - Undefined: no LFSR is built, and `receive_ready` equals registered `enable`.

## Structure
- Shared package or include (`Noc_parameters.v` additions):
  - header field offsets (`Noc_Hdr_Dst_X_Lsb` etc.)
  - the payload-index width (16)
  - the counter widths
- Sub-module: `noc_lfsr16`, instantiated only under `NOC_CHECKER_BACKPRESSURE_EN`. Everything else is a single module.

## Test plan
- Single-flit packet, header+tail, dst=(X_ID,Y_ID), src=(2,3) -> `pkt_done`=1, `pkt_good`=1, `pkt_count`=1, `flit_count`=1, `last_src`=(2,3).
- 4-flit packet with payload 1,2,3 (last flit is tail) -> `pkt_count`=1, `flit_count`=4, `err_count`=0; then payload 1,5,3 -> `err_count`=1, `pkt_good`=0, `pkt_count` unchanged.
- Header with wrong dst_x, then 2 body flits and a tail -> `err_count`=1, `err_flag`=1, `pkt_done` with `pkt_good`=0, FSM back in IDLE.
- Orphan body flit in IDLE, then a header arriving in BODY -> each adds 1 error; the aborted packet gives no `pkt_done`; the new packet completes good.
- Saturation and clear: preload via 65 540 error flits -> `err_count` holds 16'hFFFF; `clear_stats` -> all 0 next cycle, `err_flag`=0.
- With the macro defined, a 1000-flit stream -> ready drops observed, no flit lost or double-counted, `flit_count`=1000; reset asserted mid-packet -> all outputs return to their reset values.

Source files
------------

// File: rtl/noc_packet_checker_pkg.sv
// Shared constants for the NoC endpoint packet checker: header field offsets,
// payload index width, statistic counter widths and backpressure LFSR seed.
// Optional feature macro used by this block: NOC_CHECKER_BACKPRESSURE_EN.
package noc_packet_checker_pkg;

    localparam int Noc_ID_X_Width = 4;
    localparam int Noc_ID_Y_Width = 4;
    localparam int Noc_Data_Width = 32;

    // Header layout from the LSB up: dst_x, dst_y, src_x, src_y
    localparam int Noc_Hdr_Dst_X_Lsb = 0;
    localparam int Noc_Hdr_Dst_Y_Lsb = Noc_Hdr_Dst_X_Lsb + Noc_ID_X_Width;
    localparam int Noc_Hdr_Src_X_Lsb = Noc_Hdr_Dst_Y_Lsb + Noc_ID_Y_Width;
    localparam int Noc_Hdr_Src_Y_Lsb = Noc_Hdr_Src_X_Lsb + Noc_ID_X_Width;

    // Payload flits carry their 1-based position in the packet in the low bits
    localparam int Noc_Payload_Idx_Width = 16;

    localparam int Noc_Pkt_Cnt_Width  = 32;
    localparam int Noc_Flit_Cnt_Width = 32;
    localparam int Noc_Err_Cnt_Width  = 16;

    localparam logic [15:0] Noc_Lfsr_Seed = 16'hACE1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } chk_state_t;

endpackage

// File: rtl/noc_packet_checker_lfsr16.sv
// Purpose: 16-bit Fibonacci LFSR (taps 16,14,13,11) driving pseudo-random stalls.
// Latency: free-running, advances every cycle from the reset seed.
// Backpressure: none; only built when NOC_CHECKER_BACKPRESSURE_EN is defined.
`ifdef NOC_CHECKER_BACKPRESSURE_EN
module noc_lfsr16
    import noc_packet_checker_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    // Right-shifting form: feedback from bit positions 0,2,3,5 enters at the MSB
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Advance the sequence every cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= Noc_Lfsr_Seed;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule
`endif

// File: rtl/noc_packet_checker.sv
// Purpose: NoC endpoint sink; checks packet framing, destination and payload, keeps saturating stats.
// Latency: stats, err_flag, last_src and pkt_done/pkt_good update on the edge after the transfer.
// Backpressure: ready = registered enable, optionally gated by an LFSR (NOC_CHECKER_BACKPRESSURE_EN).
module noc_packet_checker
    import noc_packet_checker_pkg::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] X_ID = '0,
    parameter logic [Noc_ID_Y_Width-1:0] Y_ID = '0
)(
    input  logic                          i_noc_clk,
    input  logic                          i_noc_rst_n,
    input  logic                          i_enable,
    input  logic                          i_clear_stats,
    input  logic                          i_receive_valid,
    output logic                          o_receive_ready,
    input  logic [Noc_Data_Width-1:0]     i_receive_flit,
    input  logic                          i_receive_is_header,
    input  logic                          i_receive_is_tail,
    output logic [Noc_Pkt_Cnt_Width-1:0]  o_pkt_count,
    output logic [Noc_Flit_Cnt_Width-1:0] o_flit_count,
    output logic [Noc_Err_Cnt_Width-1:0]  o_err_count,
    output logic                          o_err_flag,
    output logic                          o_pkt_done,
    output logic                          o_pkt_good,
    output logic [Noc_ID_X_Width-1:0]     o_last_src_x,
    output logic [Noc_ID_Y_Width-1:0]     o_last_src_y
);

    chk_state_t                       r_state;
    logic [Noc_Payload_Idx_Width-1:0] r_idx;
    logic                             r_bad;
    logic                             r_enable;
    logic                             r_pkt_done;
    logic                             r_pkt_good;
    logic [Noc_ID_X_Width-1:0]        r_src_x;
    logic [Noc_ID_Y_Width-1:0]        r_src_y;
    logic [Noc_Pkt_Cnt_Width-1:0]     r_pkt_cnt;
    logic [Noc_Flit_Cnt_Width-1:0]    r_flit_cnt;
    logic [Noc_Err_Cnt_Width-1:0]     r_err_cnt;
    logic                             r_err_flag;

    logic w_xfer;
    logic w_dst_ok;
    logic w_data_ok;
    logic w_err;
    logic w_done;
    logic w_good;
    logic w_unused_flit_hi;

    // Bits above the header/payload fields carry no meaning for this checker
    assign w_unused_flit_hi = ^i_receive_flit[Noc_Data_Width-1:Noc_Payload_Idx_Width];

    // Ready is a flop copy of enable so it never depends on receive_valid
    always_ff @(posedge i_noc_clk or negedge i_noc_rst_n) begin
        if (!i_noc_rst_n) begin
            r_enable <= 1'b0;
        end else begin
            r_enable <= i_enable;
        end
    end

`ifdef NOC_CHECKER_BACKPRESSURE_EN
    logic [15:0] w_lfsr;
    logic        w_unused_lfsr_hi;

    noc_lfsr16 u_lfsr (
        .i_clk   (i_noc_clk),
        .i_rst_n (i_noc_rst_n),
        .o_lfsr  (w_lfsr)
    );

    assign w_unused_lfsr_hi = ^w_lfsr[15:2];
    assign o_receive_ready  = r_enable & (w_lfsr[1:0] != 2'b00);
`else
    assign o_receive_ready = r_enable;
`endif

    assign w_xfer    = i_receive_valid & o_receive_ready;
    assign w_dst_ok  = (i_receive_flit[Noc_Hdr_Dst_X_Lsb +: Noc_ID_X_Width] == X_ID) &&
                       (i_receive_flit[Noc_Hdr_Dst_Y_Lsb +: Noc_ID_Y_Width] == Y_ID);
    assign w_data_ok = (i_receive_flit[Noc_Payload_Idx_Width-1:0] == r_idx);

    // Classify the accepted flit: a single error event per flit, completion and its verdict
    always_comb begin
        w_err  = 1'b0;
        w_done = 1'b0;
        w_good = 1'b0;
        if (w_xfer) begin
            if (i_receive_is_header) begin
                // A header inside a packet aborts it; framing and dst errors merge into one
                w_err  = (r_state == ST_BODY) | ~w_dst_ok;
                w_done = i_receive_is_tail;
                w_good = w_dst_ok;
            end else if (r_state == ST_IDLE) begin
                w_err = 1'b1;
            end else begin
                w_err  = ~w_data_ok;
                w_done = i_receive_is_tail;
                w_good = ~r_bad & w_data_ok;
            end
        end
    end

    // Packet framing FSM with registered completion pulse and last source ID
    always_ff @(posedge i_noc_clk or negedge i_noc_rst_n) begin
        if (!i_noc_rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_bad      <= 1'b0;
            r_pkt_done <= 1'b0;
            r_pkt_good <= 1'b0;
            r_src_x    <= '0;
            r_src_y    <= '0;
        end else begin
            r_pkt_done <= w_done;
            r_pkt_good <= w_done & w_good;
            if (w_xfer) begin
                if (i_receive_is_header) begin
                    r_src_x <= i_receive_flit[Noc_Hdr_Src_X_Lsb +: Noc_ID_X_Width];
                    r_src_y <= i_receive_flit[Noc_Hdr_Src_Y_Lsb +: Noc_ID_Y_Width];
                    if (i_receive_is_tail) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_BODY;
                        r_idx   <= Noc_Payload_Idx_Width'(1);
                        r_bad   <= ~w_dst_ok;
                    end
                end else if (r_state == ST_BODY) begin
                    if (i_receive_is_tail) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_bad <= r_bad | ~w_data_ok;
                        if (r_idx != '1) begin
                            r_idx <= r_idx + Noc_Payload_Idx_Width'(1);
                        end
                    end
                end
            end
        end
    end

    // Saturating statistics; clear_stats wins over any same-cycle increment
    always_ff @(posedge i_noc_clk or negedge i_noc_rst_n) begin
        if (!i_noc_rst_n) begin
            r_pkt_cnt  <= '0;
            r_flit_cnt <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (i_clear_stats) begin
            r_pkt_cnt  <= '0;
            r_flit_cnt <= '0;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else begin
            if (w_xfer && (r_flit_cnt != '1)) begin
                r_flit_cnt <= r_flit_cnt + Noc_Flit_Cnt_Width'(1);
            end
            if (w_done && w_good && (r_pkt_cnt != '1)) begin
                r_pkt_cnt <= r_pkt_cnt + Noc_Pkt_Cnt_Width'(1);
            end
            if (w_err) begin
                r_err_flag <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + Noc_Err_Cnt_Width'(1);
                end
            end
        end
    end

    assign o_pkt_count  = r_pkt_cnt;
    assign o_flit_count = r_flit_cnt;
    assign o_err_count  = r_err_cnt;
    assign o_err_flag   = r_err_flag;
    assign o_pkt_done   = r_pkt_done;
    assign o_pkt_good   = r_pkt_good;
    assign o_last_src_x = r_src_x;
    assign o_last_src_y = r_src_y;

endmodule

// File: tb/tb_noc_packet_checker.sv
// Bench for noc_packet_checker: randomized and directed flit streams against a packet-level
// reference model; expected completions are queued by the driver and popped by a monitor.
// Works with or without NOC_CHECKER_BACKPRESSURE_EN (transfers follow the DUT's ready).
module tb_noc_packet_checker;
    import noc_packet_checker_pkg::*;

    localparam logic [3:0] XI = 4'd5;
    localparam logic [3:0] YI = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        vld = 1'b0;
    logic        is_hdr = 1'b0;
    logic        is_tail = 1'b0;
    logic [31:0] flit = '0;
    logic        rdy;
    logic [31:0] pkt_count;
    logic [31:0] flit_count;
    logic [15:0] err_count;
    logic        err_flag;
    logic        pkt_done;
    logic        pkt_good;
    logic [3:0]  src_x;
    logic [3:0]  src_y;

    noc_packet_checker #(.X_ID(XI), .Y_ID(YI)) dut (
        .i_noc_clk           (clk),
        .i_noc_rst_n         (rst_n),
        .i_enable            (enable),
        .i_clear_stats       (clear),
        .i_receive_valid     (vld),
        .o_receive_ready     (rdy),
        .i_receive_flit      (flit),
        .i_receive_is_header (is_hdr),
        .i_receive_is_tail   (is_tail),
        .o_pkt_count         (pkt_count),
        .o_flit_count        (flit_count),
        .o_err_count         (err_count),
        .o_err_flag          (err_flag),
        .o_pkt_done          (pkt_done),
        .o_pkt_good          (pkt_good),
        .o_last_src_x        (src_x),
        .o_last_src_y        (src_y)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int stall_waits = 0;

    typedef struct {
        longint good;
        longint pkt;
        longint flits;
        longint errs;
        longint sx;
        longint sy;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: packet-level view of the stream
    longint m_pkt, m_flit, m_err, m_flag, m_sx, m_sy;
    bit     m_inpkt;
    bit     m_bad;
    int     m_idx;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_pkt = 0; m_flit = 0; m_err = 0; m_flag = 0; m_sx = 0; m_sy = 0;
        m_inpkt = 0; m_bad = 0; m_idx = 0;
    endfunction

    function automatic void model_clear();
        m_pkt = 0; m_flit = 0; m_err = 0; m_flag = 0;
    endfunction

    function automatic void model_accept(input bit h, input bit t, input logic [31:0] d);
        bit   err, done, good, dst_ok, ok;
        exp_t e;
        err = 0; done = 0; good = 0;
        dst_ok = (d[3:0] == XI) && (d[7:4] == YI);
        ok = (int'(d[15:0]) == m_idx);
        if (m_flit < 64'hFFFF_FFFF) m_flit++;
        if (h) begin
            err = m_inpkt || !dst_ok;
            m_sx = longint'(d[11:8]);
            m_sy = longint'(d[15:12]);
            if (t) begin
                done = 1; good = dst_ok; m_inpkt = 0;
            end else begin
                m_inpkt = 1; m_idx = 1; m_bad = !dst_ok;
            end
        end else if (!m_inpkt) begin
            err = 1;
        end else begin
            err = !ok;
            if (t) begin
                done = 1; good = !m_bad && ok; m_inpkt = 0;
            end else begin
                m_bad = m_bad || !ok;
                if (m_idx < 65535) m_idx++;
            end
        end
        if (err) begin
            m_flag = 1;
            if (m_err < 65535) m_err++;
        end
        if (done && good && m_pkt < 64'hFFFF_FFFF) m_pkt++;
        if (done) begin
            e.good = longint'(good); e.pkt = m_pkt; e.flits = m_flit; e.errs = m_err;
            e.sx = m_sx; e.sy = m_sy;
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [3:0] dx, input logic [3:0] dy,
                                           input logic [3:0] sx, input logic [3:0] sy);
        logic [31:0] r;
        r = $urandom;
        r[15:0] = {sy, sx, dy, dx};
        return r;
    endfunction

    function automatic logic [31:0] mk_pay(input int idx);
        logic [31:0] r;
        r = $urandom;
        r[15:0] = idx[15:0];
        return r;
    endfunction

    // Called at a negedge; the flit transfers on the first posedge where ready is high
    task automatic send(input bit h, input bit t, input logic [31:0] d);
        int guard;
        guard = 0;
        vld = 1'b1; is_hdr = h; is_tail = t; flit = d;
        while (!rdy && guard < 1000) begin
            @(negedge clk);
            guard++;
            stall_waits++;
        end
        if (!rdy) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: ready=%0b, required 1 within 1000 cycles", rdy);
            vld = 1'b0;
            return;
        end
        model_accept(h, t, d);
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_pkt_count"}, longint'(pkt_count), m_pkt);
        chk({tag, "_flit_count"}, longint'(flit_count), m_flit);
        chk({tag, "_err_count"}, longint'(err_count), m_err);
        chk({tag, "_err_flag"}, longint'(err_flag), m_flag);
        chk({tag, "_src_x"}, longint'(src_x), m_sx);
        chk({tag, "_src_y"}, longint'(src_y), m_sy);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, longint'(rdy), 0);
        chk({tag, "_pkt_count"}, longint'(pkt_count), 0);
        chk({tag, "_flit_count"}, longint'(flit_count), 0);
        chk({tag, "_err_count"}, longint'(err_count), 0);
        chk({tag, "_err_flag"}, longint'(err_flag), 0);
        chk({tag, "_pkt_done"}, longint'(pkt_done), 0);
        chk({tag, "_pkt_good"}, longint'(pkt_good), 0);
        chk({tag, "_src_x"}, longint'(src_x), 0);
        chk({tag, "_src_y"}, longint'(src_y), 0);
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (pkt_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pkt_done_unexpected: pkt_done=1, required 0 (no completion pending)");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_pkt_good", longint'(pkt_good), e.good);
                    chk("done_pkt_count", longint'(pkt_count), e.pkt);
                    chk("done_flit_count", longint'(flit_count), e.flits);
                    chk("done_err_count", longint'(err_count), e.errs);
                    chk("done_src_x", longint'(src_x), e.sx);
                    chk("done_src_y", longint'(src_y), e.sy);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] dx;
        model_reset();
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single-flit packet
        send(1, 1, mk_hdr(XI, YI, 4'd2, 4'd3));
        check_stats("single");
        chk("single_pkt_count_abs", longint'(pkt_count), 1);

        // 4-flit good packet, then one with a bad payload
        send(1, 0, mk_hdr(XI, YI, 4'd7, 4'd1));
        send(0, 0, mk_pay(1));
        send(0, 0, mk_pay(2));
        send(0, 1, mk_pay(3));
        check_stats("good4");
        chk("good4_flit_count_abs", longint'(flit_count), 5);
        send(1, 0, mk_hdr(XI, YI, 4'd7, 4'd1));
        send(0, 0, mk_pay(1));
        send(0, 0, mk_pay(5));
        send(0, 1, mk_pay(3));
        check_stats("badpay");
        chk("badpay_err_abs", longint'(err_count), 1);

        // Wrong destination X, packet still consumed to its tail
        send(1, 0, mk_hdr(XI + 4'd1, YI, 4'd4, 4'd4));
        send(0, 0, mk_pay(1));
        send(0, 0, mk_pay(2));
        send(0, 1, mk_pay(3));
        check_stats("baddst");
        chk("baddst_err_abs", longint'(err_count), 2);

        // Orphan in IDLE, then a header that aborts a packet in BODY
        send(0, 0, mk_pay(1));
        send(1, 0, mk_hdr(XI, YI, 4'd1, 4'd1));
        send(0, 0, mk_pay(1));
        send(1, 0, mk_hdr(XI, YI, 4'd6, 4'd8));
        send(0, 0, mk_pay(1));
        send(0, 1, mk_pay(2));
        check_stats("abort");
        chk("abort_err_abs", longint'(err_count), 4);
        chk("abort_pkt_abs", longint'(pkt_count), 3);

        // Saturate err_count, then clear on a cycle that also carries an error flit
        for (int i = 0; i < 65540; i++) send(0, 0, $urandom & 32'hFFFF_FFFE);
        check_stats("sat");
        chk("sat_err_abs", longint'(err_count), 65535);
        clear = 1'b1;
        send(0, 0, mk_pay(3));
        clear = 1'b0;
        model_clear();
        check_stats("clear");
        chk("clear_err_flag_abs", longint'(err_flag), 0);

        // 1000-flit stream with enable held high
        stall_waits = 0;
        for (int p = 0; p < 100; p++) begin
            send(1, 0, mk_hdr(XI, YI, p[3:0], p[7:4]));
            for (int i = 1; i <= 9; i++) send(0, i == 9, mk_pay(i));
        end
        check_stats("stream");
        chk("stream_flit_abs", longint'(flit_count), 1000);
        chk("stream_pkt_abs", longint'(pkt_count), 100);
`ifdef NOC_CHECKER_BACKPRESSURE_EN
        n_checks++;
        if (stall_waits == 0) begin
            n_errors++;
            $display("FAIL stream_ready_drops: got %0d stall cycles, required > 0", stall_waits);
        end
`else
        chk("stream_ready_drops", stall_waits, 0);
`endif

        // Randomized packets: bad dst/payload, orphans, aborts, gaps, enable toggles
        for (int p = 0; p < 150; p++) begin
            int len;
            len = $urandom_range(1, 6);
            if ($urandom_range(0, 99) < 6 && !m_inpkt) send(0, $urandom_range(0, 1) == 1, $urandom);
            dx = ($urandom_range(0, 9) == 0) ? 4'($urandom) : XI;
            send(1, len == 1, mk_hdr(dx, YI, 4'($urandom), 4'($urandom)));
            for (int i = 1; i < len; i++) begin
                if (i == len - 1 && $urandom_range(0, 14) == 0) break;
                send(0, i == len - 1, ($urandom_range(0, 11) == 0) ? mk_pay(i + 1) : mk_pay(i));
            end
            if ($urandom_range(0, 9) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                enable = 1'b1;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        if (m_inpkt) send(0, 1, mk_pay(m_idx));
        check_stats("random");

        // Reset in the middle of a packet
        send(1, 0, mk_hdr(XI, YI, 4'd3, 4'd12));
        send(0, 0, mk_pay(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 0, mk_pay(2));
        send(1, 1, mk_hdr(XI, YI, 4'd9, 4'd2));
        check_stats("post_rst");

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
